fsm_state_register_param: RTL and testbench

//  Parametrised state register for the memory-integration FSMs; successor to the fixed 2-bit

---
 rtl/fsm_state_register_param.sv | 142 ++++++++++++++
 tb/tb_fsm_state_register_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_state_register_param.sv
// Parametrised FSM state register: load enable, synchronous clear, illegal-state recovery,
// saturating dwell counter with timeout escape, and change/timeout pulses.
// Optional macro FSM_PREV_STATE_EN implements the prev_state register; otherwise it is a constant.
module fsm_state_register_param #(
  parameter int STATE_W     = 2,
  parameter int NUM_STATES  = 4,
  parameter int RESET_STATE = 0,
  parameter int DWELL_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [STATE_W-1:0] next_state,
  input  logic [DWELL_W-1:0] timeout_limit,
  input  logic [STATE_W-1:0] timeout_state,
  output logic [STATE_W-1:0] current_state,
  output logic [STATE_W-1:0] prev_state,
  output logic [DWELL_W-1:0] dwell_cnt,
  output logic               state_changed,
  output logic               timeout,
  output logic               illegal_err
);

  // update | meaning
  // HOLD   | en low: everything holds, pulses clear
  // CLR    | sync_clr: back to RESET_STATE, error cleared
  // ILLEGAL| next_state out of range: recover to RESET_STATE, flag error
  // TIMEOUT| dwell reached limit while asked to stay: escape to timeout_state
  // LOAD   | legal new state
  // STAY   | same state, dwell counts up
  typedef enum logic [2:0] {
    UPD_HOLD,
    UPD_CLR,
    UPD_ILLEGAL,
    UPD_TIMEOUT,
    UPD_LOAD,
    UPD_STAY
  } upd_e;

  localparam logic [STATE_W-1:0] RST_S     = STATE_W'(RESET_STATE);
  localparam logic [STATE_W:0]   NUM_S     = (STATE_W+1)'(NUM_STATES);
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  upd_e               upd;
  logic               ns_legal;
  logic               ts_legal;
  logic               tmo_hit;
  logic [STATE_W-1:0] state_n;
  logic [DWELL_W-1:0] dwell_n;
  logic               ill_n;
  logic               tmo_n;
  logic               chg_n;

  assign ns_legal = ({1'b0, next_state} < NUM_S);
  assign ts_legal = ({1'b0, timeout_state} < NUM_S);

  // Equality, not >=: a limit lowered below the running count waits for re-entry.
  assign tmo_hit = (timeout_limit != '0) && (dwell_cnt == timeout_limit)
                   && (next_state == current_state);

  always_comb begin
    upd = UPD_HOLD;
    if (sync_clr)                       upd = UPD_CLR;
    else if (!en)                       upd = UPD_HOLD;
    else if (!ns_legal)                 upd = UPD_ILLEGAL;
    else if (tmo_hit)                   upd = UPD_TIMEOUT;
    else if (next_state != current_state) upd = UPD_LOAD;
    else                                upd = UPD_STAY;
  end

  always_comb begin
    state_n = current_state;
    dwell_n = dwell_cnt;
    ill_n   = illegal_err;
    tmo_n   = 1'b0;
    case (upd)
      UPD_CLR: begin
        state_n = RST_S;
        dwell_n = '0;
        ill_n   = 1'b0;
      end
      UPD_ILLEGAL: begin
        state_n = RST_S;
        dwell_n = '0;
        ill_n   = 1'b1;
      end
      UPD_TIMEOUT: begin
        dwell_n = '0;
        tmo_n   = 1'b1;
        if (ts_legal) begin
          state_n = timeout_state;
        end else begin
          state_n = RST_S;
          ill_n   = 1'b1;
        end
      end
      UPD_LOAD: begin
        state_n = next_state;
        dwell_n = '0;
      end
      UPD_STAY: begin
        if (dwell_cnt != DWELL_MAX) dwell_n = dwell_cnt + 1'b1;
      end
      default: begin
        state_n = current_state;
      end
    endcase
  end

  // A timeout back into the same state is not a change.
  assign chg_n = (state_n != current_state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_state <= RST_S;
      dwell_cnt     <= '0;
      illegal_err   <= 1'b0;
      timeout       <= 1'b0;
      state_changed <= 1'b0;
    end else begin
      current_state <= state_n;
      dwell_cnt     <= dwell_n;
      illegal_err   <= ill_n;
      timeout       <= tmo_n;
      state_changed <= chg_n;
    end
  end

`ifdef FSM_PREV_STATE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_state <= RST_S;
    end else if (chg_n) begin
      prev_state <= current_state;
    end
  end
`else
  assign prev_state = RST_S;
`endif

endmodule

// File: tb/tb_fsm_state_register_param.sv
// Bench for fsm_state_register_param (NUM_STATES=3, DWELL_W=4): directed literal checks plus
// random stimulus compared each cycle against an integer reference model.
module tb_fsm_state_register_param;

  localparam int SW  = 2;
  localparam int NS  = 3;
  localparam int DW  = 4;
  localparam int DMX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic [SW-1:0] next_state = '0;
  logic [DW-1:0] timeout_limit = '0;
  logic [SW-1:0] timeout_state = '0;
  logic [SW-1:0] current_state;
  logic [SW-1:0] prev_state;
  logic [DW-1:0] dwell_cnt;
  logic          state_changed;
  logic          timeout;
  logic          illegal_err;

  int n_chk  = 0;
  int n_pass = 0;

  int m_cs = 0, m_prev = 0, m_dw = 0, m_ill = 0, m_chg = 0, m_tmo = 0;
  int m_old, m_nxt;

  fsm_state_register_param #(
    .STATE_W(SW), .NUM_STATES(NS), .RESET_STATE(0), .DWELL_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .next_state(next_state), .timeout_limit(timeout_limit), .timeout_state(timeout_state),
    .current_state(current_state), .prev_state(prev_state), .dwell_cnt(dwell_cnt),
    .state_changed(state_changed), .timeout(timeout), .illegal_err(illegal_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  function automatic int exp_prev();
`ifdef FSM_PREV_STATE_EN
    return m_prev;
`else
    return 0;
`endif
  endfunction

  // Reference model: rules applied directly to integer state.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cs = 0; m_prev = 0; m_dw = 0; m_ill = 0; m_chg = 0; m_tmo = 0;
    end else begin
      m_old = m_cs;
      m_nxt = m_old;
      m_tmo = 0;
      if (sync_clr) begin
        m_nxt = 0; m_dw = 0; m_ill = 0;
      end else if (!en) begin
        m_nxt = m_old;
      end else if (int'(next_state) >= NS) begin
        m_nxt = 0; m_ill = 1; m_dw = 0;
      end else if (timeout_limit != 0 && m_dw == int'(timeout_limit)
                   && int'(next_state) == m_old) begin
        m_tmo = 1; m_dw = 0;
        if (int'(timeout_state) >= NS) begin m_nxt = 0; m_ill = 1; end
        else m_nxt = int'(timeout_state);
      end else if (int'(next_state) != m_old) begin
        m_nxt = int'(next_state); m_dw = 0;
      end else begin
        m_dw = (m_dw + 1 > DMX) ? DMX : m_dw + 1;
      end
      m_chg = (m_nxt != m_old) ? 1 : 0;
      if (m_chg != 0) m_prev = m_old;
      m_cs = m_nxt;
    end
  end

  always @(negedge clk) begin
    check("cmp_state",   int'(current_state), m_cs);
    check("cmp_prev",    int'(prev_state),    exp_prev());
    check("cmp_dwell",   int'(dwell_cnt),     m_dw);
    check("cmp_changed", int'(state_changed), m_chg);
    check("cmp_timeout", int'(timeout),       m_tmo);
    check("cmp_illegal", int'(illegal_err),   m_ill);
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    en = 1'b1; next_state = 2'd3;
    step(2);
    check("rst_state", int'(current_state), 0);
    check("rst_dwell", int'(dwell_cnt), 0);
    check("rst_flags", int'({state_changed, timeout, illegal_err}), 0);
    check("rst_prev", int'(prev_state), 0);

    rst = 1'b1; next_state = 2'd2;
    step();
    check("load_state", int'(current_state), 2);
    check("load_chg", int'(state_changed), 1);
    check("load_dwell", int'(dwell_cnt), 0);
    step();
    check("hold_chg", int'(state_changed), 0);
    step(4);
    check("hold_dwell5", int'(dwell_cnt), 5);
    en = 1'b0;
    step(3);
    check("en0_dwell", int'(dwell_cnt), 5);
    check("en0_state", int'(current_state), 2);

    en = 1'b1; timeout_limit = 4'd3; timeout_state = 2'd1;
    step();
    check("lim_below_no_tmo", int'(timeout), 0);
    check("lim_below_dwell", int'(dwell_cnt), 6);
    next_state = 2'd0; step();
    next_state = 2'd2; step();
    step(3);
    check("pre_tmo_dwell", int'(dwell_cnt), 3);
    check("pre_tmo_flag", int'(timeout), 0);
    step();
    check("tmo_state", int'(current_state), 1);
    check("tmo_flag", int'(timeout), 1);
    check("tmo_chg", int'(state_changed), 1);
    check("tmo_dwell", int'(dwell_cnt), 0);
`ifdef FSM_PREV_STATE_EN
    check("tmo_prev", int'(prev_state), 2);
`else
    check("tmo_prev", int'(prev_state), 0);
`endif
    next_state = 2'd1; step();
    check("post_tmo_pulse", int'(timeout), 0);
    check("post_tmo_dwell", int'(dwell_cnt), 1);

    next_state = 2'd3; step();
    check("ill_state", int'(current_state), 0);
    check("ill_flag", int'(illegal_err), 1);
    next_state = 2'd1; step();
    check("ill_sticky", int'(illegal_err), 1);
    check("ill_recover_load", int'(current_state), 1);
    sync_clr = 1'b1; step();
    check("clr_state", int'(current_state), 0);
    check("clr_ill", int'(illegal_err), 0);
    check("clr_chg", int'(state_changed), 1);

    next_state = 2'd3; step();
    check("prio_state", int'(current_state), 0);
    check("prio_ill", int'(illegal_err), 0);
    check("prio_chg", int'(state_changed), 0);

    sync_clr = 1'b0; next_state = 2'd1; timeout_limit = 4'd1; timeout_state = 2'd3;
    step(2);
    check("ts_pre_dwell", int'(dwell_cnt), 1);
    step();
    check("ts_ill_state", int'(current_state), 0);
    check("ts_ill_flag", int'(illegal_err), 1);
    check("ts_ill_tmo", int'(timeout), 1);

    sync_clr = 1'b1; step();
    sync_clr = 1'b0; next_state = 2'd0; timeout_limit = 4'd2; timeout_state = 2'd0;
    step(2);
    step();
    check("tmo_same_flag", int'(timeout), 1);
    check("tmo_same_chg", int'(state_changed), 0);
    check("tmo_same_dwell", int'(dwell_cnt), 0);

    timeout_limit = 4'd0;
    step(20);
    check("sat_dwell", int'(dwell_cnt), 15);

    #2 rst = 1'b0;
    #1;
    check("async_rst_dwell", int'(dwell_cnt), 0);
    check("async_rst_state", int'(current_state), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom % 10) != 0;
      sync_clr = ($urandom % 25) == 0;
      if (($urandom % 4) < 2) next_state = SW'(m_cs);
      else next_state = SW'($urandom % 4);
      if (($urandom % 16) == 0) timeout_limit = DW'($urandom % 6);
      if (($urandom % 8) == 0) timeout_state = SW'($urandom % 4);
      if (($urandom % 200) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      step();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
